state_history: RTL and testbench
================================

// Module: state_history
// PURPOSE
//   Parametrised multi-stage state history buffer: generalises the single
//   previous-state register to a DEPTH-deep delay line of WIDTH-bit samples.
//   Adds a gated shift, a selectable tap, a signed sample-to-sample delta, a
//   change flag and a fill counter. Feeds the neuron update / spike logic
//   with past membrane/state values.
// PARAMETERS
//   WIDTH   8  bit width of one state sample
//   DEPTH   4  number of history stages (>= 2)
//   TAP_W   $clog2(DEPTH)  width of tap_sel (derived, do not override)
//   CNT_W   $clog2(DEPTH+1)  width of fill_count (derived, do not override)
// PORTS
//   clk         in   1          rising-edge clock
//   reset       in   1          asynchronous reset, active-high
//   clear       in   1          synchronous flush, active-high
//   shift_en    in   1          capture state and shift history this cycle
//   state       in   WIDTH      current state sample
//   tap_sel     in   TAP_W      history stage to show on tap_state (0 = newest)
//   prev_state  out  WIDTH      hist[0], the most recently captured sample
//   tap_state   out  WIDTH      hist[tap_sel]
//   delta       out  WIDTH+1    signed (state - hist[0]) at the last shift
//   changed     out  1          one-cycle flag: last shift saw state != hist[0]
//   fill_count  out  CNT_W      number of valid stages, saturates at DEPTH
//   full        out  1          fill_count == DEPTH
// BEHAVIOUR
//   - Storage: hist[0..DEPTH-1], all WIDTH bits, registered.
//   - reset = 1: asynchronously forces every hist stage, delta, changed
//     and fill_count to 0, so all outputs read 0 without waiting for a clock
//     edge. Applies mid-operation. Normal operation resumes on the first clk
//     edge after reset is released.
//   - Priority at each posedge clk: clear > shift_en > hold.
//   - clear = 1: same zeroing as reset, done synchronously. state is not
//     captured, even when shift_en = 1 in the same cycle.
//   - shift_en = 1, clear = 0:
//       hist[0] <= state; hist[i] <= hist[i-1] for i = 1..DEPTH-1;
//       hist[DEPTH-1] is discarded.
//       delta <= {1'b0,state} - {1'b0,hist[0]} (WIDTH+1 two's complement,
//       range -(2^WIDTH-1)..+(2^WIDTH-1), never overflows).
//       changed <= (state != hist[0]).
//       fill_count <= min(fill_count+1, DEPTH).
//   - shift_en = 0, clear = 0:
//       hist, delta and fill_count hold their values; changed <= 0.
//       changed is therefore a single-cycle pulse per differing shift.
//   - Latency: a captured sample appears on prev_state one cycle after the
//     edge where shift_en = 1. It reaches stage k after k+1 shifts.
//   - tap_state: combinational mux of the registered hist array on tap_sel,
//     no extra latency. tap_sel >= DEPTH (non-power-of-2 DEPTH) -> 0.
//   - full: combinational compare on fill_count. Shifting while full is
//     legal; the oldest sample drops and fill_count stays at DEPTH.
//   - After reset the hist stages hold 0, which is treated as a real prior
//     sample: the first shift of a nonzero state sets changed = 1 and gives
//     a nonzero delta.
// TESTING (WIDTH=8, DEPTH=4 unless stated)
//   1. Shift 0x11,0x22,0x33 then assert reset between edges -> all outputs
//      0 immediately, before the next edge; fill_count=0.
//   2. Shift 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> prev_state=0x55,
//      tap_sel=3 gives 0x22, fill_count=4, full=1 (saturated, 0x11 dropped).
//   3. Shift 0x10 then 0x05 -> delta=9'h1F5 (-11). Then shift 0xFF ->
//      delta=9'h0FA (+250).
//   4. Shift 0x40 twice -> changed=1 then 0. Then hold shift_en=0 for 2 cycles
//      -> changed=0 and prev_state/delta/fill_count unchanged.
//   5. Buffer full, clear=1 and shift_en=1 with state=0x99 -> next cycle all
//      hist=0, fill_count=0, changed=0; 0x99 not captured.
//   6. DEPTH=3 build, tap_sel=3 -> tap_state=0; tap_sel=2 after shifting
//      0xA1,0xB2,0xC3 -> 0xA1.

Source files
------------

// File: rtl/state_history.sv
// state_history: DEPTH-deep delay line of state samples with tap mux, signed delta,
// change pulse and saturating fill counter.
module state_history #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int TAP_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] state,
   input  logic [TAP_W-1:0] tap_sel,
   output logic [WIDTH-1:0] prev_state,
   output logic [WIDTH-1:0] tap_state,
   output logic [WIDTH:0]   delta,
   output logic             changed,
   output logic [CNT_W-1:0] fill_count,
   output logic             full
);
   logic [WIDTH-1:0] hist_q [DEPTH];
   logic [WIDTH-1:0] hist_d [DEPTH];
   logic [WIDTH:0]   delta_q, delta_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      hist_d    = hist_q;
      delta_d   = delta_q;
      changed_d = 1'b0;
      cnt_d     = cnt_q;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
         delta_d = '0;
         cnt_d   = '0;
      end else if (shift_en) begin
         hist_d[0] = state;
         for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
         delta_d   = {1'b0, state} - {1'b0, hist_q[0]};
         changed_d = state != hist_q[0];
         cnt_d     = full ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
         delta_q   <= '0;
         changed_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         hist_q    <= hist_d;
         delta_q   <= delta_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
      end
   end

   // Out-of-range taps (non-power-of-2 DEPTH) fall through to zero.
   always_comb begin
      tap_state = '0;
      for (int i = 0; i < DEPTH; i++) if (tap_sel == TAP_W'(i)) tap_state = hist_q[i];
   end

   assign prev_state = hist_q[0];
   assign delta      = delta_q;
   assign changed    = changed_q;
   assign fill_count = cnt_q;
   assign full       = cnt_q == CNT_W'(DEPTH);
endmodule

// File: tb/tb_state_history.sv
// tb_state_history: directed scenario tasks for state_history (DEPTH=4 and DEPTH=3 builds).
module tb_state_history;
   logic       clk = 1'b0;
   logic       reset, clear, shift_en;
   logic [7:0] state;
   logic [1:0] tap_sel, tap_sel3;
   logic [7:0] prev_state, tap_state, prev3, tap3;
   logic [8:0] delta, delta3;
   logic       changed, full, changed3, full3;
   logic [2:0] fill_count;
   logic [1:0] fill3;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   state_history #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en), .state(state),
      .tap_sel(tap_sel), .prev_state(prev_state), .tap_state(tap_state), .delta(delta),
      .changed(changed), .fill_count(fill_count), .full(full)
   );

   state_history #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en), .state(state),
      .tap_sel(tap_sel3), .prev_state(prev3), .tap_state(tap3), .delta(delta3),
      .changed(changed3), .fill_count(fill3), .full(full3)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic step(input logic clr, input logic en, input logic [7:0] s);
      clear = clr; shift_en = en; state = s;
      @(posedge clk); #1;
      clear = 1'b0; shift_en = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; clear = 1'b0; shift_en = 1'b0; state = 8'h00; tap_sel = 2'd0; tap_sel3 = 2'd0;
      #12;
      total_cnt++; if (prev_state !== 8'h00) $display("FAIL reset_prev got %h exp 00", prev_state); else pass_cnt++;
      total_cnt++; if (fill_count !== 3'd0) $display("FAIL reset_fill got %0d exp 0", fill_count); else pass_cnt++;
      @(posedge clk); #1; reset = 1'b0;
      step(1'b0, 1'b1, 8'h11); step(1'b0, 1'b1, 8'h22); step(1'b0, 1'b1, 8'h33);
      total_cnt++; if (prev_state !== 8'h33) $display("FAIL pre_reset_prev got %h exp 33", prev_state); else pass_cnt++;
      total_cnt++; if (fill_count !== 3'd3) $display("FAIL pre_reset_fill got %0d exp 3", fill_count); else pass_cnt++;
      #2 reset = 1'b1; #1;
      total_cnt++; if (prev_state !== 8'h00) $display("FAIL async_prev got %h exp 00", prev_state); else pass_cnt++;
      tap_sel = 2'd2;
      #1;
      total_cnt++; if (tap_state !== 8'h00) $display("FAIL async_tap got %h exp 00", tap_state); else pass_cnt++;
      total_cnt++; if (delta !== 9'h000) $display("FAIL async_delta got %h exp 000", delta); else pass_cnt++;
      total_cnt++; if (changed !== 1'b0) $display("FAIL async_changed got %b exp 0", changed); else pass_cnt++;
      total_cnt++; if (fill_count !== 3'd0) $display("FAIL async_fill got %0d exp 0", fill_count); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL async_full got %b exp 0", full); else pass_cnt++;
      @(posedge clk); #1; reset = 1'b0;
   endtask

   task automatic test_saturate;
      step(1'b0, 1'b1, 8'h11); step(1'b0, 1'b1, 8'h22); step(1'b0, 1'b1, 8'h33);
      total_cnt++; if (full !== 1'b0) $display("FAIL sat_notfull got %b exp 0", full); else pass_cnt++;
      step(1'b0, 1'b1, 8'h44); step(1'b0, 1'b1, 8'h55);
      tap_sel = 2'd3; #1;
      total_cnt++; if (tap_state !== 8'h22) $display("FAIL sat_tap3 got %h exp 22", tap_state); else pass_cnt++;
      tap_sel = 2'd1; #1;
      total_cnt++; if (tap_state !== 8'h44) $display("FAIL sat_tap1 got %h exp 44", tap_state); else pass_cnt++;
      tap_sel = 2'd0; #1;
      total_cnt++; if (tap_state !== 8'h55) $display("FAIL sat_tap0 got %h exp 55", tap_state); else pass_cnt++;
      total_cnt++; if (prev_state !== 8'h55) $display("FAIL sat_prev got %h exp 55", prev_state); else pass_cnt++;
      total_cnt++; if (fill_count !== 3'd4) $display("FAIL sat_fill got %0d exp 4", fill_count); else pass_cnt++;
      total_cnt++; if (full !== 1'b1) $display("FAIL sat_full got %b exp 1", full); else pass_cnt++;
      total_cnt++; if (delta !== 9'h011) $display("FAIL sat_delta got %h exp 011", delta); else pass_cnt++;
   endtask

   task automatic test_delta;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h10);
      total_cnt++; if (delta !== 9'h010) $display("FAIL delta_first got %h exp 010", delta); else pass_cnt++;
      total_cnt++; if (changed !== 1'b1) $display("FAIL delta_first_chg got %b exp 1", changed); else pass_cnt++;
      step(1'b0, 1'b1, 8'h05);
      total_cnt++; if (delta !== 9'h1F5) $display("FAIL delta_neg got %h exp 1f5", delta); else pass_cnt++;
      step(1'b0, 1'b1, 8'hFF);
      total_cnt++; if (delta !== 9'h0FA) $display("FAIL delta_pos got %h exp 0fa", delta); else pass_cnt++;
      step(1'b0, 1'b1, 8'h00);
      total_cnt++; if (delta !== 9'h101) $display("FAIL delta_min got %h exp 101", delta); else pass_cnt++;
   endtask

   task automatic test_changed_hold;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h40);
      total_cnt++; if (changed !== 1'b1) $display("FAIL chg_first got %b exp 1", changed); else pass_cnt++;
      step(1'b0, 1'b1, 8'h40);
      total_cnt++; if (changed !== 1'b0) $display("FAIL chg_same got %b exp 0", changed); else pass_cnt++;
      total_cnt++; if (delta !== 9'h000) $display("FAIL chg_same_delta got %h exp 000", delta); else pass_cnt++;
      step(1'b0, 1'b1, 8'h41);
      total_cnt++; if (changed !== 1'b1) $display("FAIL chg_diff got %b exp 1", changed); else pass_cnt++;
      step(1'b0, 1'b0, 8'h77); step(1'b0, 1'b0, 8'h78);
      tap_sel = 2'd1; #1;
      total_cnt++; if (changed !== 1'b0) $display("FAIL hold_changed got %b exp 0", changed); else pass_cnt++;
      total_cnt++; if (prev_state !== 8'h41) $display("FAIL hold_prev got %h exp 41", prev_state); else pass_cnt++;
      total_cnt++; if (delta !== 9'h001) $display("FAIL hold_delta got %h exp 001", delta); else pass_cnt++;
      total_cnt++; if (fill_count !== 3'd3) $display("FAIL hold_fill got %0d exp 3", fill_count); else pass_cnt++;
      total_cnt++; if (tap_state !== 8'h40) $display("FAIL hold_tap1 got %h exp 40", tap_state); else pass_cnt++;
   endtask

   task automatic test_clear_priority;
      step(1'b0, 1'b1, 8'h01); step(1'b0, 1'b1, 8'h02); step(1'b0, 1'b1, 8'h03); step(1'b0, 1'b1, 8'h04);
      total_cnt++; if (full !== 1'b1) $display("FAIL clr_prefull got %b exp 1", full); else pass_cnt++;
      step(1'b1, 1'b1, 8'h99);
      tap_sel = 2'd3; #1;
      total_cnt++; if (prev_state !== 8'h00) $display("FAIL clr_prev got %h exp 00", prev_state); else pass_cnt++;
      total_cnt++; if (tap_state !== 8'h00) $display("FAIL clr_tap3 got %h exp 00", tap_state); else pass_cnt++;
      total_cnt++; if (fill_count !== 3'd0) $display("FAIL clr_fill got %0d exp 0", fill_count); else pass_cnt++;
      total_cnt++; if (changed !== 1'b0) $display("FAIL clr_changed got %b exp 0", changed); else pass_cnt++;
      total_cnt++; if (delta !== 9'h000) $display("FAIL clr_delta got %h exp 000", delta); else pass_cnt++;
      step(1'b0, 1'b1, 8'h07);
      tap_sel = 2'd1; #1;
      total_cnt++; if (tap_state !== 8'h00) $display("FAIL clr_nocapture got %h exp 00", tap_state); else pass_cnt++;
      total_cnt++; if (delta !== 9'h007) $display("FAIL clr_after_delta got %h exp 007", delta); else pass_cnt++;
   endtask

   task automatic test_depth3;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hA1); step(1'b0, 1'b1, 8'hB2); step(1'b0, 1'b1, 8'hC3);
      tap_sel3 = 2'd2; #1;
      total_cnt++; if (tap3 !== 8'hA1) $display("FAIL d3_tap2 got %h exp a1", tap3); else pass_cnt++;
      tap_sel3 = 2'd3; #1;
      total_cnt++; if (tap3 !== 8'h00) $display("FAIL d3_tap3 got %h exp 00", tap3); else pass_cnt++;
      total_cnt++; if (full3 !== 1'b1 || fill3 !== 2'd3) $display("FAIL d3_full got %b/%0d exp 1/3", full3, fill3); else pass_cnt++;
      step(1'b0, 1'b1, 8'hD4);
      tap_sel3 = 2'd2; #1;
      total_cnt++; if (tap3 !== 8'hB2) $display("FAIL d3_drop got %h exp b2", tap3); else pass_cnt++;
      total_cnt++; if (prev3 !== 8'hD4) $display("FAIL d3_prev got %h exp d4", prev3); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_saturate;
      test_delta;
      test_changed_hold;
      test_clear_priority;
      test_depth3;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
